// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, halt word, state encoding and word types for the fetch sequencer
package fetch_pkg;
  localparam int IW = 10;
  localparam int DW = 9;
  localparam int CW = 16;
  typedef logic [IW-1:0] pc_t;
  typedef logic [DW-1:0] inst_t;
  typedef logic [CW-1:0] cnt_t;
  localparam inst_t HALT_CODE = 9'b111111111;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
endpackage

// File: rtl/pc_next.sv
// pc_next: next-PC mux; in pc/inst_pc/target/take/rel, out next_pc (increment, absolute or wrapping relative)
module pc_next
  import fetch_pkg::*;
(
  input  pc_t  pc,
  input  pc_t  inst_pc,
  input  pc_t  target,
  input  logic take,
  input  logic rel,
  output pc_t  next_pc
);
  always_comb next_pc = take ? (rel ? inst_pc + target : target) : pc + IW'(1);
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC/IR fetch sequencer; in Start/Stall/Branch*/InstIn, out InstAddress/InstOut/InstPC/InstValid/Busy/Done/CycleCount
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [IW-1:0] BranchTarget,
  output logic [IW-1:0] InstAddress,
  input  logic [DW-1:0] InstIn,
  output logic [DW-1:0] InstOut,
  output logic [IW-1:0] InstPC,
  output logic          InstValid,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] CycleCount
);
  state_t state_q, state_d;
  pc_t    pc_q, pc_d, inst_pc_q, inst_pc_d, npc;
  inst_t  ir_q, ir_d;
  logic   valid_q, valid_d;
  cnt_t   cyc_q, cyc_d;
  logic   take;
  assign take = valid_q && BranchEn;
  pc_next u_pc_next (
    .pc      (pc_q),
    .inst_pc (inst_pc_q),
    .target  (BranchTarget),
    .take    (take),
    .rel     (BranchRel),
    .next_pc (npc)
  );
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    cyc_d     = cyc_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = RUN;
        pc_d    = '0;
        ir_d    = '0;
        valid_d = 1'b0;
        cyc_d   = '0;
      end
      RUN: if (!Stall) begin
        cyc_d = &cyc_q ? cyc_q : cyc_q + CW'(1);
        if (valid_q && ir_q == HALT_CODE) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (take) begin
          pc_d    = npc;
          valid_d = 1'b0;
        end else begin
          ir_d      = InstIn;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = npc;
        end
      end
      HALT: state_d = Start ? HALT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      cyc_q     <= cyc_d;
    end
  assign InstAddress = pc_q;
  assign InstOut     = ir_q;
  assign InstPC      = inst_pc_q;
  assign InstValid   = valid_q;
  assign Busy        = state_q == RUN;
  assign Done        = state_q == HALT;
  assign CycleCount  = cyc_q;
endmodule
